// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA raster timing generator: default 640x480@60 timing,
// run-state encoding and a width helper for the counters.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_DLY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2w(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that lines up de/hsync/vsync with the pixel pipeline;
// reset loads every stage with the inactive pattern so pins stay quiet.
module vga_sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= {DEPTH{RST_VAL}};
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on the system clock with a pixel-tick enable;
// starts/stops on frame boundaries and delays de/syncs to match the pixel pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   PIPE_DLY  = DEF_PIPE_DLY,
    localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW        = clog2w(H_TOTAL),
    localparam int  VW        = clog2w(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic          pix_tick_o,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          valid_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic          de_o,
    output logic          hsync_o,
    output logic          vsync_o
);

    localparam int            DW       = clog2w(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [2:0]    DLY_RST  = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          valid_q, valid_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;
    logic          run_d, hs_d, vs_d, last_pix;
    logic [2:0]    dly_in, dly_out;

    // Free-running divider; the tick register is aligned with the cycle whose count is CLK_DIV-1.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d = (div_d == DIV_LAST);
    end

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        last_pix = (h_q == H_LAST) && (v_q == V_LAST);
        if (tick_q) begin
            unique case (state_q)
                IDLE:    if (en_i) state_d = RUN;
                // A stop request on the very last pixel has nothing left to drain.
                RUN:     if (!en_i) state_d = last_pix ? IDLE : DRAIN;
                DRAIN:   if (en_i) state_d = RUN;
                         else if (last_pix) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (state_q != IDLE) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
        end
    end

    // Flags are decoded from next-state values so the registered copies line up with h_q/v_q.
    always_comb begin
        run_d   = (state_d != IDLE);
        valid_d = run_d && (h_d < H_ACT) && (v_d < V_ACT);
        hs_d    = run_d && (h_d >= HS_BEG) && (h_d <= HS_END);
        vs_d    = run_d && (v_d >= VS_BEG) && (v_d <= VS_END);
        ls_d    = tick_d && run_d && (h_d == '0);
        fs_d    = ls_d && (v_d == '0);
        dly_in  = {valid_d, hs_d ^ ~HSYNC_POL, vs_d ^ ~VSYNC_POL};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            valid_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            h_q     <= h_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    // Stage 0 is the registered copy aligned with the counters; PIPE_DLY more stages follow.
    vga_sync_delay #(
        .WIDTH  (3),
        .DEPTH  (PIPE_DLY + 1),
        .RST_VAL(DLY_RST)
    ) u_sync_delay (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (dly_in),
        .q_o  (dly_out)
    );

    assign pix_tick_o    = tick_q;
    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign valid_o       = valid_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;
    assign de_o          = dly_out[2];
    assign hsync_o       = dly_out[1];
    assign vsync_o       = dly_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small-raster instance (CLK_DIV=4, 15x8 total, delay 2) and a tiny
// CLK_DIV=1 instance with positive syncs and no delay.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // A: 8/2/3/2 x 4/1/2/1 -> 15x8, frame 480 clks, hs at h 10..12, vs at v 5..6
    logic       a_rst, a_en, a_tick, a_valid, a_ls, a_fs, a_de, a_hs, a_vs;
    logic [3:0] a_h;
    logic [2:0] a_v;
    // B: 4/1/1/1 x 3/1/1/1 -> 7x6, CLK_DIV=1, hs at h=5, vs at v=4
    logic       b_rst, b_en, b_tick, b_valid, b_ls, b_fs, b_de, b_hs, b_vs;
    logic [2:0] b_h;
    logic [2:0] b_v;

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DLY(2)
    ) dut_a (
        .clk_i(clk), .rst_i(a_rst), .en_i(a_en), .pix_tick_o(a_tick),
        .h_cnt_o(a_h), .v_cnt_o(a_v), .valid_o(a_valid), .line_start_o(a_ls),
        .frame_start_o(a_fs), .de_o(a_de), .hsync_o(a_hs), .vsync_o(a_vs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DLY(0)
    ) dut_b (
        .clk_i(clk), .rst_i(b_rst), .en_i(b_en), .pix_tick_o(b_tick),
        .h_cnt_o(b_h), .v_cnt_o(b_v), .valid_o(b_valid), .line_start_o(b_ls),
        .frame_start_o(b_fs), .de_o(b_de), .hsync_o(b_hs), .vsync_o(b_vs)
    );

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_tick, a_h, a_v, a_valid, a_ls, a_fs, a_de} !== 12'd0) begin
            errors++;
            $display("FAIL reset_a_zero: tick=%b h=%0d v=%0d valid=%b ls=%b fs=%b de=%b, want all 0",
                     a_tick, a_h, a_v, a_valid, a_ls, a_fs, a_de);
        end
        checks++;
        if (a_hs !== 1'b1 || a_vs !== 1'b1) begin
            errors++;
            $display("FAIL reset_a_sync: hsync=%b vsync=%b, want 1 1", a_hs, a_vs);
        end
        checks++;
        if (b_hs !== 1'b0 || b_vs !== 1'b0 || b_tick !== 1'b0 || b_de !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: hsync=%b vsync=%b tick=%b de=%b, want 0 0 0 0", b_hs, b_vs, b_tick, b_de);
        end
    endtask

    // Release with en=1: tick after 3 edges, IDLE->RUN on edge 4, frame_start on edge 7.
    task automatic test_startup;
        int early;
        early = 0;
        a_en = 1'b1;
        a_rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k < 7 && a_fs) early++;
            if (k < 3 && a_tick) early++;
            if (k == 3) begin
                checks++;
                if (a_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL startup_tick: tick=%b at edge 3, want 1", a_tick);
                end
            end
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL startup_early: %0d early tick/frame_start pulses, want 0", early);
        end
        checks++;
        if (a_fs !== 1'b1 || a_h !== 4'd0 || a_v !== 3'd0) begin
            errors++;
            $display("FAIL startup_fs: fs=%b h=%0d v=%0d at edge 7, want 1 0 0", a_fs, a_h, a_v);
        end
    endtask

    task automatic test_frame;
        int n, vt, ls, de, hl, vl;
        n = 0; vt = 0; ls = 0; de = 0; hl = 0; vl = 0;
        do begin
            vt += int'(a_valid && a_tick);
            ls += int'(a_ls);
            de += int'(a_de);
            hl += int'(!a_hs);
            vl += int'(!a_vs);
            @(negedge clk);
            n++;
        end while (!a_fs && n < 2000);
        checks++;
        if (n != 480) begin errors++; $display("FAIL frame_period: %0d clks, want 480", n); end
        checks++;
        if (vt != 32) begin errors++; $display("FAIL frame_valid_ticks: %0d, want 32", vt); end
        checks++;
        if (ls != 8) begin errors++; $display("FAIL frame_line_starts: %0d, want 8", ls); end
        checks++;
        if (de != 128) begin errors++; $display("FAIL frame_de_clks: %0d, want 128", de); end
        checks++;
        if (hl != 96) begin errors++; $display("FAIL frame_hsync_low: %0d clks, want 96", hl); end
        checks++;
        if (vl != 120) begin errors++; $display("FAIL frame_vsync_low: %0d clks, want 120", vl); end
    endtask

    task automatic test_sync_align;
        int t_h, t_hs, t_v, t_de;
        logic hp, hsp, vp, dep;
        logic [3:0] hcp;
        t_h = -100; t_hs = -1; t_v = -100; t_de = -1;
        hcp = a_h; hsp = a_hs; vp = a_valid; dep = a_de;
        for (int n = 0; n < 200 && (t_hs < 0 || t_de < 0); n++) begin
            @(negedge clk);
            if (a_h == 4'd10 && hcp != 4'd10) t_h = cyc;
            if (!a_hs && hsp && t_hs < 0) t_hs = cyc;
            if (a_valid && !vp) t_v = cyc;
            if (a_de && !dep && t_de < 0) t_de = cyc;
            hcp = a_h; hsp = a_hs; vp = a_valid; dep = a_de;
        end
        hp = 1'b0;
        checks++;
        if (t_hs < 0 || t_hs - t_h != 2) begin
            errors++;
            $display("FAIL hsync_fall_delay: %0d clks after h=10, want 2", t_hs - t_h);
        end
        checks++;
        if (t_de < 0 || t_de - t_v != 2 || hp) begin
            errors++;
            $display("FAIL de_rise_delay: %0d clks after valid, want 2", t_de - t_v);
        end
    endtask

    task automatic test_drain;
        int n, fs, vt, bad, ticks;
        n = 0;
        while (a_v != 3'd2 && n < 1000) begin @(negedge clk); n++; end
        a_en = 1'b0;
        n = 0; fs = 0; vt = 0;
        while (!(a_h == 4'd14 && a_v == 3'd7) && n < 1000) begin
            fs += int'(a_fs);
            vt += int'(a_valid && a_tick);
            @(negedge clk); n++;
        end
        while (a_h == 4'd14 && a_v == 3'd7 && n < 1010) begin @(negedge clk); n++; end
        checks++;
        if (n >= 1000) begin errors++; $display("FAIL drain_timeout: %0d clks, want < 1000", n); end
        checks++;
        if (fs != 0 || vt != 16) begin
            errors++;
            $display("FAIL drain_count: fs=%0d valid_ticks=%0d, want 0 16", fs, vt);
        end
        bad = 0; ticks = 0;
        for (int k = 0; k < 40; k++) begin
            if (a_h != 0 || a_v != 0 || a_valid || a_fs || a_ls || !a_hs || !a_vs) bad++;
            ticks += int'(a_tick);
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_hold: %0d bad cycles, want 0", bad); end
        checks++;
        if (ticks != 10) begin errors++; $display("FAIL idle_ticks: %0d, want 10", ticks); end
        a_en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_fs && n < 12);
        checks++;
        if (!a_fs || n < 4 || n > 8 || a_h != 0 || a_v != 0) begin
            errors++;
            $display("FAIL restart_fs: fs=%b after %0d clks h=%0d v=%0d, want 1 in 4..8 at 0,0", a_fs, n, a_h, a_v);
        end
    endtask

    task automatic test_en_glitch;
        int n, brk;
        logic [3:0] hp;
        n = 0; brk = 0; hp = a_h;
        do begin
            @(negedge clk); n++;
            if (n == 100) a_en = 1'b0;
            if (n == 140) a_en = 1'b1;
            if (!(a_h == hp || a_h == hp + 1 || (hp == 4'd14 && a_h == 4'd0))) brk++;
            hp = a_h;
        end while (!a_fs && n < 2000);
        checks++;
        if (n != 480) begin errors++; $display("FAIL glitch_period: %0d clks, want 480", n); end
        checks++;
        if (brk != 0) begin errors++; $display("FAIL glitch_continuity: %0d breaks, want 0", brk); end
    endtask

    task automatic test_tiny;
        int bad, hs_hi, fs;
        b_en = 1'b1;
        b_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (b_fs !== 1'b1 || b_h !== 3'd0 || b_v !== 3'd0 || b_tick !== 1'b1) begin
            errors++;
            $display("FAIL tiny_start: fs=%b h=%0d v=%0d tick=%b, want 1 0 0 1", b_fs, b_h, b_v, b_tick);
        end
        bad = 0; hs_hi = 0; fs = 0;
        for (int k = 0; k < 84; k++) begin
            @(negedge clk);
            checks++;
            if (b_tick !== 1'b1 || b_hs !== (b_h == 3'd5) || b_vs !== (b_v == 3'd4) ||
                b_valid !== (b_h < 3'd4 && b_v < 3'd3)) begin
                errors++;
                $display("FAIL tiny_cycle: h=%0d v=%0d tick=%b hs=%b vs=%b valid=%b", b_h, b_v, b_tick, b_hs, b_vs, b_valid);
            end
            hs_hi += int'(b_hs);
            fs += int'(b_fs);
        end
        checks++;
        if (hs_hi != 12 || fs != 2) begin
            errors++;
            $display("FAIL tiny_counts: hsync_hi=%0d fs=%0d, want 12 2", hs_hi, fs);
        end
    endtask

    task automatic test_async_reset;
        int n, early;
        n = 0;
        while (a_h != 4'd6 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk);
        #2 a_rst = 1'b1;
        #1;
        checks++;
        if ({a_tick, a_h, a_v, a_valid, a_ls, a_fs, a_de} !== 12'd0 || a_hs !== 1'b1 || a_vs !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: tick=%b h=%0d v=%0d valid=%b de=%b hs=%b vs=%b, want 0s and syncs 1",
                     a_tick, a_h, a_v, a_valid, a_de, a_hs, a_vs);
        end
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        early = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k < 7 && a_fs) early++;
        end
        checks++;
        if (early != 0 || a_fs !== 1'b1 || a_h !== 4'd0 || a_v !== 3'd0) begin
            errors++;
            $display("FAIL async_restart: early=%0d fs=%b h=%0d v=%0d, want 0 1 0 0", early, a_fs, a_h, a_v);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_frame();
        test_sync_align();
        test_drain();
        test_en_glitch();
        test_tiny();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
